// File: rtl/pc_sequencer_fsm.sv
// Multicycle instruction sequencer: owns PC write enable / next-PC select,
// IR / register-file / data-memory write strobes, and a retired-instruction counter.
module pc_sequencer_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b100000,
    parameter logic [5:0] OP_ADDI  = 6'b111000,
    parameter logic [5:0] OP_LW    = 6'b001111,
    parameter logic [5:0] OP_SW    = 6'b011111,
    parameter logic [5:0] OP_BEQ   = 6'b000000,
    parameter logic [5:0] OP_J     = 6'b111111,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PC_WE,
    output logic [1:0]       PC_sel,
    output logic             IR_WE,
    output logic             RF_WE,
    output logic             MEM_WE,
    output logic             mem_req,
    output logic             illegal_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    // state  | meaning
    // FETCH  | request instruction word; on ready load IR and PC <= PC+4
    // DECODE | jump completes here, illegal opcodes abort, others go to EXEC
    // EXEC   | branch resolves here; loads/stores go to MEM, ALU ops to WB
    // MEM    | data access, stalls until ready; store retires on ready
    // WB     | one-cycle register-file write, instruction retires
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] SEL_PC4    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;

    state_t            state_q;
    state_t            state_d;
    logic              retire;
    logic [CNT_W-1:0]  instr_count_q;

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; reset gates every strobe so nothing writes in that cycle.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        PC_WE      = 1'b0;
        PC_sel     = SEL_PC4;
        IR_WE      = 1'b0;
        RF_WE      = 1'b0;
        MEM_WE     = 1'b0;
        mem_req    = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IR_WE   = 1'b1;
                    PC_WE   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_J) begin
                    PC_WE   = 1'b1;
                    PC_sel  = SEL_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_RTYPE || opcode == OP_ADDI || opcode == OP_LW ||
                             opcode == OP_SW    || opcode == OP_BEQ) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                if (opcode == OP_BEQ) begin
                    PC_sel  = SEL_BRANCH;
                    PC_WE   = zero;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM;
                end else if (opcode == OP_RTYPE || opcode == OP_ADDI) begin
                    state_d = S_WB;
                end else begin
                    // Opcode changed under us after decode: abandon without writing.
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (opcode == OP_SW) begin
                    MEM_WE = mem_ready;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (opcode == OP_LW) begin
                    if (mem_ready) begin
                        state_d = S_WB;
                    end
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RF_WE   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            state_d    = S_FETCH;
            retire     = 1'b0;
            PC_WE      = 1'b0;
            PC_sel     = SEL_PC4;
            IR_WE      = 1'b0;
            RF_WE      = 1'b0;
            MEM_WE     = 1'b0;
            mem_req    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer_fsm.sv
// Self-checking bench for pc_sequencer_fsm: per-cycle expected rows are queued
// alongside the stimulus and compared as the DUT steps through them.
module tb_pc_sequencer_fsm;

    localparam logic [5:0] RT  = 6'b100000;
    localparam logic [5:0] ADI = 6'b111000;
    localparam logic [5:0] LW  = 6'b001111;
    localparam logic [5:0] SW  = 6'b011111;
    localparam logic [5:0] BEQ = 6'b000000;
    localparam logic [5:0] JMP = 6'b111111;
    localparam logic [5:0] ILL = 6'b101010;

    logic        CLK = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PC_WE, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op;
    logic [1:0]  PC_sel;
    logic [2:0]  state;
    logic [31:0] instr_count;

    logic        PC_WE_n, IR_WE_n, RF_WE_n, MEM_WE_n, mem_req_n, illegal_op_n;
    logic [1:0]  PC_sel_n;
    logic [2:0]  state_n;
    logic [2:0]  instr_count_n;

    pc_sequencer_fsm dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PC_WE(PC_WE), .PC_sel(PC_sel), .IR_WE(IR_WE), .RF_WE(RF_WE), .MEM_WE(MEM_WE),
        .mem_req(mem_req), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
    );

    // Narrow-counter copy driven by the same inputs, so counter wrap is exercised in a few cycles.
    pc_sequencer_fsm #(.CNT_W(3)) dut_n (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PC_WE(PC_WE_n), .PC_sel(PC_sel_n), .IR_WE(IR_WE_n), .RF_WE(RF_WE_n), .MEM_WE(MEM_WE_n),
        .mem_req(mem_req_n), .illegal_op(illegal_op_n), .state(state_n), .instr_count(instr_count_n)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic        pcwe;
        logic [1:0]  sel;
        logic        irwe;
        logic        rfwe;
        logic        memwe;
        logic        req;
        logic        ill;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        sb[$];
    logic [31:0] exp_cnt = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Queue one cycle of stimulus with the outputs expected during that cycle.
    function automatic void push(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                                 input logic [2:0] st, input logic pcwe, input logic [1:0] sel,
                                 input logic irwe, input logic rfwe, input logic memwe,
                                 input logic req, input logic ill, input logic ret);
        cyc_t c;
        c.rst = rst; c.op = op; c.z = z; c.rdy = rdy; c.st = st; c.pcwe = pcwe; c.sel = sel;
        c.irwe = irwe; c.rfwe = rfwe; c.memwe = memwe; c.req = req; c.ill = ill; c.cnt = exp_cnt;
        sb.push_back(c);
        if (rst) exp_cnt = 32'd0;
        else if (ret) exp_cnt = exp_cnt + 32'd1;
    endfunction

    task automatic test_reset();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(1, RT,  0, 1, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(1, JMP, 1, 1, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    task automatic test_rtype();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(1, RT, 0, 1, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, RT, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, RT, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, RT, 0, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, RT, 0, 1, 3'd4, 0, 2'd0, 0, 1, 0, 0, 0, 1);
        push(0, RT, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rtype cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    task automatic test_lw_stall();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(1, LW, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            push(0, LW, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        push(0, LW, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, LW, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, LW, 0, 0, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            push(0, LW, 0, 0, 3'd3, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        push(0, LW, 0, 1, 3'd3, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        push(0, LW, 0, 1, 3'd4, 0, 2'd0, 0, 1, 0, 0, 0, 1);
        push(0, LW, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lw_stall cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    task automatic test_beq();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(1, BEQ, 1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, BEQ, 1, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, BEQ, 1, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, BEQ, 1, 1, 3'd2, 1, 2'd1, 0, 0, 0, 0, 0, 1);
        push(0, BEQ, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, BEQ, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, BEQ, 0, 1, 3'd2, 0, 2'd1, 0, 0, 0, 0, 0, 1);
        push(0, BEQ, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL beq cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    task automatic test_jump_illegal();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(1, JMP, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, JMP, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, JMP, 0, 1, 3'd1, 1, 2'd2, 0, 0, 0, 0, 0, 1);
        push(0, ILL, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, ILL, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 1, 0);
        push(0, ILL, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL jump_illegal cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    // Count carries over (1) so the mid-access reset visibly clears it.
    task automatic test_sw_reset();
        cyc_t e;
        logic [45:0] got, want;
        int k = 0;
        push(0, SW, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, SW, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, SW, 0, 0, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, SW, 0, 0, 3'd3, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        push(1, SW, 0, 0, 3'd3, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, SW, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
        push(0, SW, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, SW, 0, 0, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(0, SW, 0, 1, 3'd3, 0, 2'd0, 0, 0, 1, 1, 0, 1);
        push(0, SW, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sw_reset cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
    endtask

    // Eight back-to-back ALU instructions: the 3-bit counter copy goes 7 -> 0 on the last retire.
    task automatic test_back_to_back_wrap();
        cyc_t e;
        logic [45:0] got, want;
        logic [5:0] op;
        int k = 0;
        push(1, RT, 0, 1, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            op = (i % 2 == 1) ? ADI : RT;
            push(0, op, 0, 1, 3'd0, 1, 2'd0, 1, 0, 0, 1, 0, 0);
            push(0, op, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
            push(0, op, 0, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
            push(0, op, 0, 1, 3'd4, 0, 2'd0, 0, 1, 0, 0, 0, 1);
        end
        push(0, RT, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset = e.rst; opcode = e.op; zero = e.z; mem_ready = e.rdy;
            #1;
            got  = {state, PC_WE, PC_sel, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op, instr_count, instr_count_n};
            want = {e.st, e.pcwe, e.sel, e.irwe, e.rfwe, e.memwe, e.req, e.ill, e.cnt, e.cnt[2:0]};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got=%h want=%h", k, got, want);
            end
            k++;
            @(negedge CLK);
        end
        n_checks++;
        if (instr_count_n !== 3'd0 || instr_count !== 32'd8) begin
            n_fail++;
            $display("FAIL wrap got narrow=%0d wide=%0d want narrow=0 wide=8", instr_count_n, instr_count);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
        @(negedge CLK);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_jump_illegal();
        test_sw_reset();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer_fsm.md
Name: pc_sequencer_fsm

Overview:
- Multicycle control sequencer that owns the program counter register's write enable and next-PC source select.
- Steps each instruction through fetch/decode/execute/memory/writeback states and stalls on a ready handshake from the shared instruction/data memory.
- Drives IR, register-file and memory write strobes and keeps a retired-instruction counter.
- Sits between the PC register, the instruction register and the datapath ALU/memory.

Parameters:
- OP_RTYPE, 6'b100000, opcode of R-type ALU instructions
- OP_ADDI, 6'b111000, opcode of add-immediate
- OP_LW, 6'b001111, opcode of load word
- OP_SW, 6'b011111, opcode of store word
- OP_BEQ, 6'b000000, opcode of branch-if-equal
- OP_J, 6'b111111, opcode of unconditional jump
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  input  1  clock; all state updates on posedge CLK
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag, sampled in EXEC
- mem_ready  input  1  memory access complete this cycle
- PC_WE  output  1  PC register write enable
- PC_sel  output  2  next PC source: 0=PC+4, 1=branch target, 2=jump target
- IR_WE  output  1  instruction register write enable
- RF_WE  output  1  register file write enable
- MEM_WE  output  1  data memory write enable
- mem_req  output  1  memory access request
- illegal_op  output  1  one-cycle pulse for an unknown opcode
- state  output  3  current state (debug): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- instr_count  output  CNT_W  retired instruction count

Behaviour:
- Outputs are combinational decodes of state, opcode, zero and mem_ready. Only state and instr_count are registered.
- Reset:
  - reset=1 at posedge forces state=FETCH and instr_count=0.
  - While reset is high, every strobe (PC_WE, IR_WE, RF_WE, MEM_WE, mem_req, illegal_op) is forced to 0 and PC_sel=0.
  - Reset overrides any transition, including one mid-instruction or during a stalled access. No writes issue in the reset cycle.
- FETCH:
  - mem_req=1.
  - If mem_ready=1: IR_WE=1, PC_WE=1, PC_sel=0; next state is DECODE.
  - If mem_ready=0: all writes are 0 and the state holds. Stalls are unbounded.
- DECODE:
  - OP_J: PC_WE=1, PC_sel=2; next FETCH; instr_count increments.
  - RTYPE, ADDI, LW, SW, BEQ: next EXEC.
  - Any other opcode: illegal_op=1 for this cycle, no writes; next FETCH; count not incremented.
- EXEC:
  - BEQ: PC_sel=1, PC_WE=zero; next FETCH; count increments whether or not the branch is taken.
  - LW, SW: next MEM.
  - RTYPE, ADDI: next WB.
- MEM:
  - mem_req=1.
  - SW: MEM_WE=mem_ready. When mem_ready=1, next FETCH and count increments.
  - LW: when mem_ready=1, next WB.
  - mem_ready=0 holds the state. MEM_WE stays 0 while stalled.
- WB:
  - RF_WE=1 for exactly one cycle; next FETCH; count increments.
- Undefined state encodings (5-7) recover to FETCH on the next edge with no writes.
- Invariants:
  - PC_WE is high for at most one cycle per FETCH.
  - PC_WE is high at most once more per instruction (jump, or taken branch).
  - RF_WE and MEM_WE are never both high.
- instr_count wraps modulo 2^CNT_W. It increments on the final-state edge of each legal instruction.
- Cycle counts with mem_ready tied high:
  - J: 2 cycles
  - BEQ: 3 cycles
  - R-type/ADDI: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles

Test Plan:
- Reset, then R-type (opcode 6'b100000) with mem_ready=1:
  - state sequence 0,1,2,4,0
  - PC_WE high only in cycle 1 with PC_sel=0
  - RF_WE high only in WB
  - instr_count=1
- LW with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM:
  - FETCH holds 3 extra cycles and MEM holds 2, with no strobes
  - then exactly one IR_WE/PC_WE pulse and one RF_WE pulse
  - total 10 cycles; count=1
- BEQ with zero=1, then BEQ with zero=0:
  - first has PC_WE=1 and PC_sel=1 in EXEC
  - second has PC_WE=0 in EXEC
  - both return to FETCH; count=2
- J (6'b111111): PC_WE pulses in FETCH (sel 0) and in DECODE (sel 2); 2 cycles total. Opcode 6'b101010: illegal_op pulses once in DECODE, returns to FETCH, count unchanged.
- SW with a reset asserted during the stalled MEM state (mem_ready=0):
  - next state is FETCH, count=0, MEM_WE never asserted
  - a following SW with mem_ready=1 gives MEM_WE=1 for exactly one cycle
- Preload instr_count near wrap (force to 2^CNT_W-1) and retire one R-type: instr_count reads 0.
